exmem_pipe_bp: RTL and testbench
================================

// Module: exmem_pipe_bp
// PURPOSE
//   Parametrised pipelined memory for the user project area with a fixed
//   programmable access latency, byte enables and in-order responses.
//   A response FIFO with credit-based request stall lets the consumer hold
//   off acks through a ready input, so no response is ever dropped.
//   Reports out-of-range addresses with err. Sits behind the WB/LA bridge.
// PARAMETERS
//   DW        32  data width in bits; multiple of 8
//   AW        10  word-address bits; memory depth = 2**AW words
//   LAT       10  request-to-ack latency in cycles; legal range 2..64
//   RSP_DEPTH 16  response FIFO entries = max outstanding requests; >= 2
// PORTS
//   clk     in   1     clock
//   rst     in   1     asynchronous reset, active-high
//   stb     in   1     request strobe
//   we      in   1     1 = write, 0 = read
//   sel     in   DW/8  byte enables; write only
//   addr    in   32    byte address; word index = addr[AW+1:2]
//   dat_i   in   DW    write data
//   stall   out  1     1 = request not accepted this cycle
//   ack     out  1     response valid
//   ack_rdy in   1     consumer accepts the response (ack && ack_rdy = pop)
//   dat_o   out  DW    read data; 0 for writes and errored reads
//   err     out  1     response is for an out-of-range address; valid with ack
// BEHAVIOUR
//   - Reset: stall=0, ack=0, dat_o=0, err=0. Pipeline valids cleared.
//     FIFO emptied, outstanding counter cleared. Memory array is not reset.
//   - Accept: stb && !stall at a rising edge. A request with stall=1 is
//     ignored, and the master holds it.
//   - Credits: outstanding (0..RSP_DEPTH) increments on accept and
//     decrements on pop. Accept and pop in the same cycle leave it unchanged.
//     stall = (outstanding == RSP_DEPTH), decoded from a register. There is
//     no combinational path from stb or ack_rdy to stall.
//   - Latency: stb is presented in cycle 0. With the FIFO empty, ack=1 in
//     cycle LAT exactly. With ack_rdy held 1, back-to-back requests give
//     back-to-back acks, so throughput is 1 per cycle.
//   - Pipeline: valid/we/sel/word-address/data delay line. The memory access
//     happens at the final stage using a registered synchronous read. The
//     result is pushed into the response FIFO, and a bypass meets the LAT
//     timing when the FIFO is empty.
//   - Ordering: strictly in order. A write at cycle t is visible to any read
//     accepted at cycle > t. A read and a write to the same word accepted in
//     consecutive cycles get read-after-write order.
//   - Write: for each byte b with sel[b]=1, mem[word][8b+7:8b] <= dat_i byte.
//     sel=0 is legal: it is a no-op write and is still acked. The response
//     has dat_o=0 and err=0.
//   - Range: word index >= 2**AW is impossible by construction. An address
//     with addr[31:AW+2] != 0 is out of range. The write is suppressed, a
//     read returns 0, and the response has err=1.
//   - Backpressure: ack with ack_rdy=0 holds ack, dat_o and err stable until
//     popped. The FIFO never overflows because credits bound in-flight plus
//     queued entries to RSP_DEPTH.
//   - Reset mid-operation: all in-flight and queued responses are discarded.
//     Writes that already reached the memory stage persist, and no later
//     writes occur. The first ack after reset belongs to a post-reset request.
// TESTING
//   1 Write 0xA5A5_0001 @0x10 sel=F, then read @0x10, ack_rdy=1. Expect
//     acks exactly LAT cycles after each stb, and read dat_o=0xA5A5_0001.
//   2 Partial write sel=0100, dat_i=0x00CC_0000, over 0x11223344, then read.
//     Expect dat_o=0x11CC3344.
//   3 Stream 32 reads with ack_rdy=1. Expect 32 consecutive ack cycles, in
//     order, starting at cycle LAT, and stall never asserted.
//   4 Hold ack_rdy=0 while issuing 20 requests with RSP_DEPTH=16. Expect
//     stall=1 after the 16th accept, and only 16 accepted. Then pulse
//     ack_rdy for 1 cycle with stb high. Expect one pop, one accept, and
//     stall back to 1.
//   5 Read at addr=0x0001_0000 (AW=10). Expect ack with err=1 and dat_o=0.
//     Write to the same address, then read word 0. Expect word 0 unchanged.
//   6 Assert rst for 1 cycle with 5 requests in flight. Expect no ack for
//     them, stall=0 and outstanding=0. A new read then acks at LAT.

Source files
------------

// File: rtl/exmem_pipe_bp.sv
// Pipelined word memory with fixed request-to-ack latency LAT, byte enables and in-order responses.
// Latency LAT cycles; a credit counter stalls requests so the response FIFO never overflows under ack_rdy backpressure.

module exmem_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign dout  = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end
endmodule

module exmem_pipe_bp #(
  parameter int DW        = 32,
  parameter int AW        = 10,
  parameter int LAT       = 10,
  parameter int RSP_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stb,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [31:0]     addr,
  input  logic [DW-1:0]   dat_i,
  output logic            stall,
  output logic            ack,
  input  logic            ack_rdy,
  output logic [DW-1:0]   dat_o,
  output logic            err
);
  localparam int NS = LAT - 1;
  localparam int SW = DW / 8;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [NS:1]   p_vld, p_we, p_err;
  logic [SW-1:0] p_sel [1:NS];
  logic [AW-1:0] p_idx [1:NS];
  logic [DW-1:0] p_dat [1:NS];

  logic [DW-1:0] mem [2**AW];

  logic          accept, pop, mem_wr;
  logic [CW-1:0] outstanding;
  logic          rsp_vld, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic [DW:0]   fifo_dout;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign stall  = (outstanding == CW'(RSP_DEPTH));
  assign accept = stb && !stall;
  assign pop    = ack && ack_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + 1'b1;
    end else if (pop && !accept) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Only the valid bits are reset, so an in-flight write dies on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld <= '0;
    end else begin
      p_vld[1] <= accept;
      for (int i = 2; i <= NS; i++) p_vld[i] <= p_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_we[1]  <= we;
    p_err[1] <= |addr[31:AW+2];
    p_sel[1] <= sel;
    p_idx[1] <= addr[AW+1:2];
    p_dat[1] <= dat_i;
    for (int i = 2; i <= NS; i++) begin
      p_we[i]  <= p_we[i-1];
      p_err[i] <= p_err[i-1];
      p_sel[i] <= p_sel[i-1];
      p_idx[i] <= p_idx[i-1];
      p_dat[i] <= p_dat[i-1];
    end
  end

  assign mem_wr = p_vld[NS] && p_we[NS] && !p_err[NS];

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < SW; b++) begin
        if (p_sel[NS][b]) mem[p_idx[NS]][8*b +: 8] <= p_dat[NS][8*b +: 8];
      end
    end
  end

  // Registered read: a write one stage ahead has already landed in mem.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      rsp_dat <= '0;
    end else begin
      rsp_vld <= p_vld[NS];
      rsp_err <= p_vld[NS] && p_err[NS];
      rsp_dat <= (p_vld[NS] && !p_we[NS] && !p_err[NS]) ? mem[p_idx[NS]] : '0;
    end
  end

  // Bypass the FIFO when it is empty and the consumer takes the response now.
  assign fifo_push = rsp_vld && !(fifo_empty && ack_rdy);
  assign fifo_pop  = !fifo_empty && ack_rdy;

  exmem_rsp_fifo #(
    .W     (DW + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({rsp_err, rsp_dat}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign ack   = rsp_vld || !fifo_empty;
  assign dat_o = fifo_empty ? rsp_dat : fifo_dout[DW-1:0];
  assign err   = fifo_empty ? rsp_err : fifo_dout[DW];
endmodule

// File: tb/tb_exmem_pipe_bp.sv
// Directed bench for exmem_pipe_bp: latency, byte enables, streaming, credit stall, range errors, mid-flight reset.
module tb_exmem_pipe_bp;
  localparam int DW        = 32;
  localparam int AW        = 10;
  localparam int LAT       = 10;
  localparam int RSP_DEPTH = 16;

  logic          clk, rst, stb, we, ack_rdy;
  logic [3:0]    sel;
  logic [31:0]   addr, dat_i, dat_o;
  logic          stall, ack, err;
  int            n_cmp, n_bad;

  exmem_pipe_bp #(.DW(DW), .AW(AW), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .sel(sel), .addr(addr),
    .dat_i(dat_i), .stall(stall), .ack(ack), .ack_rdy(ack_rdy),
    .dat_o(dat_o), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int k);
    return 32'hC0DE_0000 + k;
  endfunction

  // One request presented at a negedge; measures cycles to ack, ends one negedge after the pop.
  task automatic single(input string tag, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
    int n;
    stb = 1'b1; we = w; sel = s; addr = a; dat_i = d;
    @(negedge clk);
    stb = 1'b0;
    n = 1;
    while (!ack && n < LAT + 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_dat"}, dat_o, exp_d);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
    @(negedge clk);
  endtask

  // Back-to-back requests to consecutive words starting at base; checks ack timing and order.
  task automatic stream(input string tag, input int n, input logic w, input int base);
    int got, first, last, stalls;
    got = 0; first = -1; last = -1; stalls = 0;
    for (int k = 0; k < n + LAT + 5; k++) begin
      if (ack) begin
        if (first < 0) first = k;
        last = k;
        chk({tag, "_dat"}, dat_o, w ? 32'd0 : pattern(got));
        got++;
      end
      if (stall) stalls++;
      if (k < n) begin
        stb = 1'b1; we = w; sel = 4'hF; addr = (base + k) * 4; dat_i = pattern(k);
      end else begin
        stb = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_first"}, first, LAT);
    chk({tag, "_count"}, got, n);
    chk({tag, "_span"}, last - first, n - 1);
    chk({tag, "_stalls"}, stalls, 0);
  endtask

  initial begin
    int acc, idx, acks;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; sel = 4'h0; addr = '0; dat_i = '0; ack_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    single("t1_wr", 1'b1, 4'hF, 32'h10, 32'hA5A5_0001, 32'd0, 1'b0);
    single("t1_rd", 1'b0, 4'hF, 32'h10, 32'd0, 32'hA5A5_0001, 1'b0);

    single("t2_wr", 1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'd0, 1'b0);
    single("t2_pw", 1'b1, 4'b0100, 32'h20, 32'h00CC_0000, 32'd0, 1'b0);
    single("t2_rd", 1'b0, 4'hF, 32'h20, 32'd0, 32'h11CC_3344, 1'b0);
    single("t2_nop", 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'd0, 1'b0);
    single("t2_rd2", 1'b0, 4'hF, 32'h20, 32'd0, 32'h11CC_3344, 1'b0);

    stream("t3_wr", 32, 1'b1, 64);
    stream("t3_rd", 32, 1'b0, 64);

    // Credit stall with the consumer holding off.
    ack_rdy = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      stb = 1'b1; we = 1'b0; sel = 4'hF; addr = (64 + acc) * 4;
      if (!stall) acc++;
      @(negedge clk);
    end
    chk("t4_accepted", acc, 16);
    chk("t4_stall", {31'd0, stall}, 32'd1);
    chk("t4_ack_held", {31'd0, ack}, 32'd1);
    chk("t4_head", dat_o, pattern(0));
    ack_rdy = 1'b1;
    addr = (64 + 16) * 4;
    @(negedge clk);
    ack_rdy = 1'b0;
    chk("t4_credit", {31'd0, stall}, 32'd0);
    chk("t4_next_head", dat_o, pattern(1));
    @(negedge clk);
    stb = 1'b0;
    chk("t4_restall", {31'd0, stall}, 32'd1);
    ack_rdy = 1'b1;
    idx = 1;
    for (int k = 0; k < 60; k++) begin
      if (ack) begin
        chk("t4_drain", dat_o, pattern(idx));
        idx++;
      end
      @(negedge clk);
    end
    chk("t4_drain_count", idx, 17);

    single("t5_w0", 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, 32'd0, 1'b0);
    single("t5_oor_rd", 1'b0, 4'hF, 32'h0001_0000, 32'd0, 32'd0, 1'b1);
    single("t5_oor_wr", 1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    single("t5_rd0", 1'b0, 4'hF, 32'h0, 32'd0, 32'h0BAD_F00D, 1'b0);

    // Reset with five requests in flight, the last a write that must not land.
    single("t6_w5", 1'b1, 4'hF, 32'h14, 32'h0000_0055, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      stb = 1'b1; we = (k == 4); sel = 4'hF;
      addr = (k == 4) ? 32'h14 : (64 + k) * 4;
      dat_i = 32'h0000_DEAD;
      @(negedge clk);
    end
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_ack", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    chk("t6_no_stale_ack", acks, 0);
    chk("t6_stall_after", {31'd0, stall}, 32'd0);
    single("t6_rd5", 1'b0, 4'hF, 32'h14, 32'd0, 32'h0000_0055, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
